// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared widths and state/owner encodings for the regfile
//               writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Owner encoding is kept distinct from the state names so both enums can
    // live in one package without literal collisions.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_A    = 2'd1,
        OWNER_B    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_A) ? OWNER_B : OWNER_A;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_grant_fsm.sv
// ============================================================================
// Module      : wb_grant_fsm
// Description : Round-robin grant FSM with bounded burst for two writeback
//               requesters. Grants are combinational; state is registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_grant_fsm #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_ready,
    output logic b_ready
);
    import rf_pkg::*;

    localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    state_e           state;
    owner_e           last_owner;
    logic [CNT_W-1:0] burst_cnt;
    owner_e           grant;
    logic             cnt_full;

    assign cnt_full = (burst_cnt >= C_BURST_MAX);

    // Current owner keeps the port until its burst is spent, and only yields
    // early when the other side is actually waiting.
    always_comb begin
        grant = OWNER_NONE;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant = other_owner(last_owner);
                end else if (a_valid) begin
                    grant = OWNER_A;
                end else if (b_valid) begin
                    grant = OWNER_B;
                end
            end
            OWN_A: begin
                if (a_valid && (!cnt_full || !b_valid)) begin
                    grant = OWNER_A;
                end else if (b_valid) begin
                    grant = OWNER_B;
                end
            end
            OWN_B: begin
                if (b_valid && (!cnt_full || !a_valid)) begin
                    grant = OWNER_B;
                end else if (a_valid) begin
                    grant = OWNER_A;
                end
            end
            default: grant = OWNER_NONE;
        endcase
        if (!rst_n) begin
            grant = OWNER_NONE;
        end
    end

    assign a_ready = (grant == OWNER_A);
    assign b_ready = (grant == OWNER_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= OWNER_B;
            burst_cnt  <= '0;
        end else begin
            case (grant)
                OWNER_A: begin
                    state      <= OWN_A;
                    last_owner <= OWNER_A;
                    if (state == OWN_A) begin
                        burst_cnt <= cnt_full ? burst_cnt : burst_cnt + C_ONE;
                    end else begin
                        burst_cnt <= C_ONE;
                    end
                end
                OWNER_B: begin
                    state      <= OWN_B;
                    last_owner <= OWNER_B;
                    if (state == OWN_B) begin
                        burst_cnt <= cnt_full ? burst_cnt : burst_cnt + C_ONE;
                    end else begin
                        burst_cnt <= C_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the registerfile write port between ALU (A) and
//               load/store (B) writeback; registered output, x0 writes dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int XLEN      = rf_pkg::XLEN,
    parameter int REG_AW    = rf_pkg::REG_AW,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_data,
    output logic              wen,
    output logic [REG_AW-1:0] wr,
    output logic [XLEN-1:0]   wd
);
    logic              xfer;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    wb_grant_fsm #(
        .BURST_MAX (BURST_MAX)
    ) u_grant (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_ready (a_ready),
        .b_ready (b_ready)
    );

    assign xfer     = (a_valid && a_ready) || (b_valid && b_ready);
    assign sel_rd   = a_ready ? a_rd   : b_rd;
    assign sel_data = a_ready ? a_data : b_data;

    // x0 transfers still load wr/wd but never raise wen, so the registerfile
    // is left untouched while the requester sees a normal handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen <= 1'b0;
            wr  <= '0;
            wd  <= '0;
        end else begin
            wen <= xfer && (sel_rd != '0);
            if (xfer) begin
                wr <= sel_rd;
                wd <= sel_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Bench for regfile_wb_arbiter with a simple registerfile model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;
    localparam int BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [REG_AW-1:0] a_rd, b_rd;
    logic [XLEN-1:0]   a_data, b_data;
    logic              wen;
    logic [REG_AW-1:0] wr;
    logic [XLEN-1:0]   wd;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .XLEN      (XLEN),
        .REG_AW    (REG_AW),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .wen     (wen),
        .wr      (wr),
        .wd      (wd)
    );

    // Registerfile stand-in: written on the clock edge, x0 reads as zero.
    logic              rf_init = 1'b1;
    logic [XLEN-1:0]   rf [32];
    logic [REG_AW-1:0] rr1;
    logic [XLEN-1:0]   rd1;

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wen) begin
            rf[wr] <= wd;
        end
    end
    assign rd1 = (rr1 == '0) ? '0 : rf[rr1];

    int total = 0;
    int bad   = 0;

    // Reference model: owner of the current run, run length, last winner
    // (0 = none, 1 = A, 2 = B) and the predicted output register contents.
    int              m_run, m_len, m_last;
    logic            p_wen;
    logic [REG_AW-1:0] p_wr;
    logic [XLEN-1:0] p_wd;
    logic [XLEN-1:0] exp_rf [32];

    int              pred_g;
    logic            obs_ar, obs_br, obs_wen;
    logic [REG_AW-1:0] obs_wr;
    logic [XLEN-1:0] obs_wd;

    function automatic int model_grant(input logic av, input logic bv);
        logic mine, theirs;
        if (m_run == 0) begin
            if (av && bv) return 3 - m_last;
            if (av) return 1;
            if (bv) return 2;
            return 0;
        end
        mine   = (m_run == 1) ? av : bv;
        theirs = (m_run == 1) ? bv : av;
        if (mine && (m_len < BURST_MAX || !theirs)) return m_run;
        if (theirs) return 3 - m_run;
        return 0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_len = 0; m_last = 2;
        p_wen = 1'b0; p_wr = '0; p_wd = '0;
    endtask

    task automatic model_commit(input int g, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                                input logic [REG_AW-1:0] brd, input logic [XLEN-1:0] bd);
        if (p_wen) exp_rf[p_wr] = p_wd;
        if (g == 0) begin
            m_run = 0; m_len = 0; p_wen = 1'b0;
        end else begin
            m_len  = (g == m_run) ? ((m_len + 1 > BURST_MAX) ? BURST_MAX : m_len + 1) : 1;
            m_run  = g;
            m_last = g;
            p_wr   = (g == 1) ? ard : brd;
            p_wd   = (g == 1) ? ad  : bd;
            p_wen  = (p_wr != '0);
        end
    endtask

    // One clock: drive at negedge, sample readies, clock, sample outputs.
    task automatic tick(input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                        input logic bv, input logic [REG_AW-1:0] brd, input logic [XLEN-1:0] bd);
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        #1;
        pred_g = model_grant(av, bv);
        obs_ar = a_ready;
        obs_br = b_ready;
        @(posedge clk);
        #1;
        model_commit(pred_g, ard, ad, brd, bd);
        obs_wen = wen; obs_wr = wr; obs_wd = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1234_5678;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        rr1 = '0;
        @(posedge clk); #1; rf_init = 1'b0;
        @(negedge clk); #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", wen); end
        total++; if (wr !== '0) begin bad++; $display("FAIL reset_wr: got %0h want 0", wr); end
        total++; if (wd !== '0) begin bad++; $display("FAIL reset_wd: got %0h want 0", wd); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL release_a_ready: got %b want 1", a_ready); end
        a_valid = 1'b0;
    endtask

    task automatic test_tie_burst();
        logic want_a;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 5'd1, 32'h0000_000a, 1'b1, 5'd2, 32'h0000_000b);
            want_a = ((i / BURST_MAX) % 2) == 0;
            total++; if (obs_ar !== want_a) begin bad++; $display("FAIL tie_a_ready beat%0d: got %b want %b", i, obs_ar, want_a); end
            total++; if (obs_br !== !want_a) begin bad++; $display("FAIL tie_b_ready beat%0d: got %b want %b", i, obs_br, !want_a); end
            total++; if (obs_wr !== (want_a ? 5'd1 : 5'd2)) begin bad++; $display("FAIL tie_wr beat%0d: got %0d want %0d", i, obs_wr, want_a ? 1 : 2); end
            total++; if (obs_wd !== p_wd || obs_wen !== 1'b1) begin bad++; $display("FAIL tie_wd beat%0d: got %0h/%b want %0h/1", i, obs_wd, obs_wen, p_wd); end
        end
        tick(1'b0, '0, '0, 1'b0, '0, '0);
        total++; if (obs_wen !== 1'b0) begin bad++; $display("FAIL tie_idle_wen: got %b want 0", obs_wen); end
    endtask

    task automatic test_single_write();
        tick(1'b1, 5'd1, 32'h0000_000a, 1'b0, '0, '0);
        total++; if (obs_ar !== 1'b1) begin bad++; $display("FAIL single_a_ready: got %b want 1", obs_ar); end
        total++; if (obs_wen !== 1'b1 || obs_wr !== 5'd1 || obs_wd !== 32'h0000_000a) begin
            bad++; $display("FAIL single_out: got wen=%b wr=%0d wd=%0h want 1/1/a", obs_wen, obs_wr, obs_wd); end
        tick(1'b0, '0, '0, 1'b0, '0, '0);
        total++; if (obs_wen !== 1'b0 || obs_wr !== 5'd1 || obs_wd !== 32'h0000_000a) begin
            bad++; $display("FAIL single_hold: got wen=%b wr=%0d wd=%0h want 0/1/a", obs_wen, obs_wr, obs_wd); end
        rr1 = 5'd1; #1;
        total++; if (rd1 !== 32'h0000_000a) begin bad++; $display("FAIL single_rd1: got %0h want a", rd1); end
    endtask

    task automatic test_x0_drop();
        tick(1'b0, '0, '0, 1'b1, 5'd0, 32'hdead_beef);
        total++; if (obs_br !== 1'b1) begin bad++; $display("FAIL x0_b_ready: got %b want 1", obs_br); end
        total++; if (obs_wen !== 1'b0) begin bad++; $display("FAIL x0_wen: got %b want 0", obs_wen); end
        total++; if (obs_wr !== p_wr || obs_wd !== p_wd) begin bad++; $display("FAIL x0_regs: got %0h/%0h want %0h/%0h", obs_wr, obs_wd, p_wr, p_wd); end
        tick(1'b0, '0, '0, 1'b0, '0, '0);
        total++; if (obs_wen !== 1'b0) begin bad++; $display("FAIL x0_wen_after: got %b want 0", obs_wen); end
        rr1 = 5'd0; #1;
        total++; if (rd1 !== '0) begin bad++; $display("FAIL x0_rd1: got %0h want 0", rd1); end
    endtask

    task automatic test_owner_release();
        logic want_a;
        for (int i = 0; i < 8; i++) begin
            tick(i != 2, 5'd6, 32'h600 + i, 1'b1, 5'd7, 32'h700 + i);
            want_a = (i < 2) || (i >= 6);
            total++; if (obs_ar !== want_a || obs_br !== !want_a) begin
                bad++; $display("FAIL release_grant beat%0d: got a=%b b=%b want a=%b", i, obs_ar, obs_br, want_a); end
            total++; if (obs_ar !== (pred_g == 1)) begin bad++; $display("FAIL release_model beat%0d: got %b want %b", i, obs_ar, pred_g == 1); end
        end
        tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_burst();
        tick(1'b1, 5'd3, 32'h0000_0055, 1'b0, '0, '0);
        total++; if (obs_ar !== 1'b1 || obs_wen !== 1'b1) begin bad++; $display("FAIL midrst_xfer: got a_ready=%b wen=%b want 1/1", obs_ar, obs_wen); end
        @(negedge clk);
        rst_n = 1'b0; a_valid = 1'b0;
        model_reset();
        #1;
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL midrst_wen: got %b want 0", wen); end
        @(negedge clk);
        rst_n = 1'b1;
        rr1 = 5'd3; #1;
        total++; if (rd1 !== exp_rf[3] || rd1 === 32'h0000_0055) begin bad++; $display("FAIL midrst_reg3: got %0h want %0h", rd1, exp_rf[3]); end
        tick(1'b1, 5'd4, 32'h444, 1'b1, 5'd5, 32'h555);
        total++; if (obs_ar !== 1'b1 || obs_br !== 1'b0) begin bad++; $display("FAIL midrst_tie: got a=%b b=%b want a=1 b=0", obs_ar, obs_br); end
        tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        logic pa, pb;
        logic [REG_AW-1:0] ra, rb;
        logic [XLEN-1:0] da, db;
        pa = 1'b0; pb = 1'b0; ra = '0; rb = '0; da = '0; db = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && ($urandom_range(0, 3) != 0)) begin pa = 1'b1; ra = REG_AW'($urandom_range(0, 31)); da = $urandom; end
            if (!pb && ($urandom_range(0, 2) != 0)) begin pb = 1'b1; rb = REG_AW'($urandom_range(0, 31)); db = $urandom; end
            tick(pa, ra, da, pb, rb, db);
            total++; if (obs_ar !== (pred_g == 1) || obs_br !== (pred_g == 2)) begin
                bad++; $display("FAIL rand_grant cyc%0d: got a=%b b=%b want g=%0d", i, obs_ar, obs_br, pred_g); end
            total++; if (obs_wen !== p_wen || obs_wr !== p_wr || obs_wd !== p_wd) begin
                bad++; $display("FAIL rand_out cyc%0d: got %b/%0h/%0h want %b/%0h/%0h", i, obs_wen, obs_wr, obs_wd, p_wen, p_wr, p_wd); end
            if (pred_g == 1) pa = 1'b0;
            if (pred_g == 2) pb = 1'b0;
        end
        tick(1'b0, '0, '0, 1'b0, '0, '0);
        tick(1'b0, '0, '0, 1'b0, '0, '0);
        for (int r = 1; r < 32; r++) begin
            rr1 = REG_AW'(r); #1;
            total++; if (rd1 !== exp_rf[r]) begin bad++; $display("FAIL rand_rf x%0d: got %0h want %0h", r, rd1, exp_rf[r]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        model_reset();
        test_reset();
        test_tie_burst();
        test_single_write();
        test_x0_drop();
        test_owner_release();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
